line_buffer_param: RTL and testbench



---
 rtl/line_buffer_pkg.sv | 14 +
 rtl/lb_col_slice.sv | 36 +++
 rtl/line_buffer_param.sv | 119 +++++++++++
 tb/tb_line_buffer_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// Shared defaults and the window-width helper for the parametrised line buffer.
package line_buffer_pkg;

  localparam int unsigned PIX_W_DEF  = 8;
  localparam int unsigned ROW_PX_DEF = 640;
  localparam int unsigned SEG_PX_DEF = 16;
  localparam int unsigned HALO_DEF   = 3;

  function automatic int unsigned win_w(input int unsigned seg, input int unsigned halo,
                                        input int unsigned pix_w);
    return (seg + 2 * halo) * pix_w;
  endfunction

endpackage

// File: rtl/lb_col_slice.sv
// Extracts one zero-padded SEG_PX+2*HALO pixel window from a single SRAM row.
module lb_col_slice
  import line_buffer_pkg::*;
#(
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned ROW_PX  = ROW_PX_DEF,
  parameter int unsigned SEG_PX  = SEG_PX_DEF,
  parameter int unsigned HALO    = HALO_DEF,
  parameter int unsigned COL_W   = 6,
  parameter int unsigned WIN_W   = win_w(SEG_PX, HALO, PIX_W)
) (
  input  logic [ROW_PX*PIX_W-1:0] i_row,
  input  logic [COL_W-1:0]        i_col,
  output logic [WIN_W-1:0]        o_win,
  output logic                    o_col_err
);

  localparam int unsigned WIN_PX  = SEG_PX + 2 * HALO;
  localparam int unsigned NUM_SEG = ROW_PX / SEG_PX;

  int w_idx;

  always_comb begin
    o_col_err = (int'(i_col) >= int'(NUM_SEG));
    o_win     = '0;
    w_idx     = 0;
    for (int j = 0; j < int'(WIN_PX); j++) begin
      // Row pixel under window pixel j; may fall off either image edge.
      w_idx = int'(i_col) * int'(SEG_PX) - int'(HALO) + j;
      if (!o_col_err && (w_idx >= 0) && (w_idx < int'(ROW_PX))) begin
        o_win[j*PIX_W +: PIX_W] = i_row[w_idx*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/line_buffer_param.sv
// Window shift register: one chain of DEPTH or NUM_IN chains of DEPTH/NUM_IN,
// with fill tracking, window-valid, flush and column-range error pulse.
module line_buffer_param
  import line_buffer_pkg::*;
#(
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned ROW_PX  = ROW_PX_DEF,
  parameter int unsigned SEG_PX  = SEG_PX_DEF,
  parameter int unsigned HALO    = HALO_DEF,
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned DEPTH   = 10,
  // Derived widths; leave at their defaults.
  parameter int unsigned WIN_W   = win_w(SEG_PX, HALO, PIX_W),
  parameter int unsigned NUM_SEG = ROW_PX / SEG_PX,
  parameter int unsigned COL_W   = $clog2(NUM_SEG),
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_buffer_mode,
  input  logic                           i_buffer_we,
  input  logic                           i_fill_zero,
  input  logic                           i_flush,
  input  logic [COL_W-1:0]               i_buffer_col,
  input  logic [NUM_IN*ROW_PX*PIX_W-1:0] i_in_data,
  output logic [DEPTH*WIN_W-1:0]         o_buffer_data,
  output logic [CNT_W-1:0]               o_fill_cnt,
  output logic                           o_win_valid,
  output logic                           o_col_err
);

  localparam int unsigned CHAIN_L = DEPTH / NUM_IN;

  if (DEPTH % NUM_IN != 0) begin : g_depth_chk
    $error("line_buffer_param: DEPTH must be a multiple of NUM_IN");
  end

  logic [NUM_IN-1:0][WIN_W-1:0] w_slice;
  logic [NUM_IN-1:0][WIN_W-1:0] w_head;
  logic [NUM_IN-1:0]            w_col_err;
  logic [DEPTH-1:0][WIN_W-1:0]  w_buf_shift;
  logic [CNT_W-1:0]             w_len;
  logic [CNT_W-1:0]             w_cnt_base;
  logic [CNT_W-1:0]             w_cnt_next;

  logic [DEPTH-1:0][WIN_W-1:0]  r_buf;
  logic [CNT_W-1:0]             r_fill_cnt;
  logic                         r_win_valid;
  logic                         r_col_err;
  logic                         r_mode;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_slice
    lb_col_slice #(
      .PIX_W  (PIX_W),
      .ROW_PX (ROW_PX),
      .SEG_PX (SEG_PX),
      .HALO   (HALO),
      .COL_W  (COL_W),
      .WIN_W  (WIN_W)
    ) u_slice (
      .i_row     (i_in_data[g*ROW_PX*PIX_W +: ROW_PX*PIX_W]),
      .i_col     (i_buffer_col),
      .o_win     (w_slice[g]),
      .o_col_err (w_col_err[g])
    );
    assign w_head[g] = i_fill_zero ? '0 : w_slice[g];
  end

  // Register k*L is a chain head only in mode 1; in mode 0 it continues the single chain.
  for (genvar k = 0; k < DEPTH; k++) begin : g_shift
    if (k == 0) begin : g_first
      assign w_buf_shift[k] = w_head[0];
    end else if (k % CHAIN_L == 0) begin : g_head
      assign w_buf_shift[k] = i_buffer_mode ? w_head[k/CHAIN_L] : r_buf[k-1];
    end else begin : g_body
      assign w_buf_shift[k] = r_buf[k-1];
    end
  end

  always_comb begin
    w_len      = i_buffer_mode ? CNT_W'(CHAIN_L) : CNT_W'(DEPTH);
    // A mode change restarts fill tracking for the new chain geometry.
    w_cnt_base = (i_buffer_mode != r_mode) ? '0 : r_fill_cnt;
    w_cnt_next = (w_cnt_base >= w_len) ? w_len : w_cnt_base + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf       <= '0;
      r_fill_cnt  <= '0;
      r_win_valid <= 1'b0;
      r_col_err   <= 1'b0;
      r_mode      <= 1'b0;
    end else begin
      r_mode <= i_buffer_mode;
      if (i_flush) begin
        r_buf       <= '0;
        r_fill_cnt  <= '0;
        r_win_valid <= 1'b0;
        r_col_err   <= 1'b0;
      end else if (i_buffer_we) begin
        r_buf       <= w_buf_shift;
        r_fill_cnt  <= w_cnt_next;
        r_win_valid <= (w_cnt_next == w_len);
        r_col_err   <= |w_col_err;
      end else begin
        r_fill_cnt  <= w_cnt_base;
        r_win_valid <= (w_cnt_base == w_len);
        r_col_err   <= 1'b0;
      end
    end
  end

  assign o_buffer_data = r_buf;
  assign o_fill_cnt    = r_fill_cnt;
  assign o_win_valid   = r_win_valid;
  assign o_col_err     = r_col_err;

endmodule

// File: tb/tb_line_buffer_param.sv
// Self-checking bench for line_buffer_param: vector table plus hand sequences,
// with expected outputs queued at drive time and checked after the clock edge.
module tb_line_buffer_param;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned ROW_PX  = 640;
  localparam int unsigned SEG_PX  = 16;
  localparam int unsigned HALO    = 3;
  localparam int unsigned NUM_IN  = 5;
  localparam int unsigned DEPTH   = 10;
  localparam int unsigned WIN_PX  = SEG_PX + 2 * HALO;
  localparam int unsigned WIN_W   = WIN_PX * PIX_W;
  localparam int unsigned NUM_SEG = ROW_PX / SEG_PX;
  localparam int unsigned COL_W   = $clog2(NUM_SEG);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           mode, we, fz, fl;
  logic [COL_W-1:0]               col;
  logic [NUM_IN*ROW_PX*PIX_W-1:0] in_data;
  logic [DEPTH*WIN_W-1:0]         buffer_data;
  logic [CNT_W-1:0]               fill_cnt;
  logic                           win_valid;
  logic                           col_err;

  line_buffer_param dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_buffer_mode (mode),
    .i_buffer_we   (we),
    .i_fill_zero   (fz),
    .i_flush       (fl),
    .i_buffer_col  (col),
    .i_in_data     (in_data),
    .o_buffer_data (buffer_data),
    .o_fill_cnt    (fill_cnt),
    .o_win_valid   (win_valid),
    .o_col_err     (col_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DEPTH*WIN_W-1:0] data;
    logic [CNT_W-1:0]       cnt;
    logic                   valid;
    logic                   err;
  } exp_t;

  typedef struct {
    logic we, fz, fl, mode;
    int   col;
    int   cnt;
    logic valid, err;
  } vec_t;

  exp_t             sb[$];
  logic [WIN_W-1:0] m_buf [DEPTH];
  int               n_checks = 0;
  int               n_fail   = 0;

  function automatic logic [WIN_W-1:0] ref_slice(input int r, input int c);
    logic [WIN_W-1:0] w;
    int px;
    w = '0;
    for (int j = 0; j < int'(WIN_PX); j++) begin
      px = c * int'(SEG_PX) - int'(HALO) + j;
      if (c < int'(NUM_SEG) && px >= 0 && px < int'(ROW_PX))
        w[j*PIX_W +: PIX_W] = in_data[(r*int'(ROW_PX) + px)*int'(PIX_W) +: PIX_W];
    end
    return w;
  endfunction

  function automatic logic [DEPTH*WIN_W-1:0] model_flat();
    logic [DEPTH*WIN_W-1:0] f;
    for (int k = 0; k < int'(DEPTH); k++) f[k*WIN_W +: WIN_W] = m_buf[k];
    return f;
  endfunction

  task automatic set_row_ramp(input int r, input int mul, input int add);
    for (int p = 0; p < int'(ROW_PX); p++)
      in_data[(r*int'(ROW_PX) + p)*int'(PIX_W) +: PIX_W] = 8'(p * mul + add);
  endtask

  task automatic set_row_const(input int r, input int v);
    for (int p = 0; p < int'(ROW_PX); p++)
      in_data[(r*int'(ROW_PX) + p)*int'(PIX_W) +: PIX_W] = 8'(v);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing to compare", tag);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (buffer_data !== e.data) begin
      n_fail++;
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (buffer_data[k*WIN_W +: WIN_W] !== e.data[k*WIN_W +: WIN_W]) begin
          $display("FAIL %s data reg%0d: got %h expected %h", tag, k,
                   buffer_data[k*WIN_W +: WIN_W], e.data[k*WIN_W +: WIN_W]);
          break;
        end
      end
    end
    n_checks++;
    if (fill_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL %s fill_cnt: got %0d expected %0d", tag, fill_cnt, e.cnt);
    end
    n_checks++;
    if (win_valid !== e.valid) begin
      n_fail++;
      $display("FAIL %s win_valid: got %b expected %b", tag, win_valid, e.valid);
    end
    n_checks++;
    if (col_err !== e.err) begin
      n_fail++;
      $display("FAIL %s col_err: got %b expected %b", tag, col_err, e.err);
    end
  endtask

  // Drive one cycle, queue the expected result, then check it after the edge.
  task automatic apply(input logic w, input logic z, input logic f, input logic m, input int c,
                       input int ecnt, input logic ev, input logic ee, input string tag);
    exp_t e;
    int   len;
    we = w; fz = z; fl = f; mode = m; col = COL_W'(c);
    if (f) begin
      for (int k = 0; k < int'(DEPTH); k++) m_buf[k] = '0;
    end else if (w) begin
      len = m ? int'(DEPTH / NUM_IN) : int'(DEPTH);
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (k % len == 0) m_buf[k] = z ? '0 : ref_slice(k / len, c);
        else              m_buf[k] = m_buf[k-1];
      end
    end
    e.data  = model_flat();
    e.cnt   = CNT_W'(ecnt);
    e.valid = ev;
    e.err   = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic chk_px(input string tag, input int k, input int j, input int exp_v);
    logic [PIX_W-1:0] act;
    act = buffer_data[(k*int'(WIN_W) + j*int'(PIX_W)) +: PIX_W];
    n_checks++;
    if (act !== 8'(exp_v)) begin
      n_fail++;
      $display("FAIL %s reg%0d px%0d: got %0d expected %0d", tag, k, j, act, exp_v);
    end
  endtask

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 5, (i + 1 > 10) ? 10 : i + 1, (i >= 9), 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 5,  10, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 5,  10, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 45, 10, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 45, 10, 1'b1, 1'b0};

    for (int k = 0; k < int'(DEPTH); k++) m_buf[k] = '0;

    // Reset dominates a concurrent write with random row data.
    rst_n = 1'b0; we = 1'b1; fz = 1'b0; fl = 1'b0; mode = 1'b0; col = COL_W'(5);
    for (int i = 0; i < int'(NUM_IN * ROW_PX * PIX_W / 32); i++) in_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{'0, '0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      compare_out("reset");
    end
    rst_n = 1'b1;
    we    = 1'b0;
    in_data = '0;
    set_row_ramp(0, 1, 0);

    for (int i = 0; i < 16; i++)
      apply(tbl[i].we, tbl[i].fz, tbl[i].fl, tbl[i].mode, tbl[i].col, tbl[i].cnt,
            tbl[i].valid, tbl[i].err, $sformatf("vec%0d", i));
    chk_px("col45_zero", 0, 0, 0);
    chk_px("col5_px0", 1, 0, 77);
    chk_px("col5_px21", 1, 21, 98);
    chk_px("col5_tail", 9, 0, 77);

    // Edge padding at both image borders.
    set_row_ramp(0, 3, 1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 10, 1'b1, 1'b0, "col0");
    for (int j = 0; j < 3; j++) chk_px("col0_pad", 0, j, 0);
    chk_px("col0_px3", 0, 3, 1);
    chk_px("col0_px4", 0, 4, 4);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 39, 10, 1'b1, 1'b0, "col39");
    chk_px("col39_px17", 0, 17, 123);
    chk_px("col39_px18", 0, 18, 126);
    for (int j = 19; j < 22; j++) chk_px("col39_pad", 0, j, 0);
    chk_px("col0_shifted", 1, 3, 1);

    // Flush wins over a concurrent out-of-range write.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 45, 0, 1'b0, 1'b0, "flush_we");

    set_row_ramp(0, 1, 0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 5, 1, 1'b0, 1'b0, "fill_zero");
    for (int i = 2; i <= 10; i++)
      apply(1'b1, 1'b0, 1'b0, 1'b0, 5, i, (i == 10), 1'b0, $sformatf("refill%0d", i));
    chk_px("zero_tail_px0", 9, 0, 0);
    chk_px("zero_tail_px10", 9, 10, 0);
    chk_px("refill_px0", 8, 0, 77);

    // Mode toggle clears fill tracking but keeps data.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 10, 0, 1'b0, 1'b0, "mode_to1");
    chk_px("mode_keep", 8, 0, 77);
    for (int g = 0; g < int'(NUM_IN); g++) set_row_const(g, g + 1);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 10, 1, 1'b0, 1'b0, "m1_w1");
    apply(1'b1, 1'b0, 1'b0, 1'b1, 10, 2, 1'b1, 1'b0, "m1_w2");
    for (int g = 0; g < int'(NUM_IN); g++) begin
      chk_px("m1_head", 2 * g, 0, g + 1);
      chk_px("m1_tail", 2 * g + 1, 21, g + 1);
    end
    set_row_ramp(2, 1, 0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 10, 2, 1'b1, 1'b0, "m1_sat");
    chk_px("m1_no_cross", 5, 0, 3);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0, "mode_to0");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 10, 1, 1'b0, 1'b0, "m0_again");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
